temp_sensor_poller: RTL and testbench
=====================================

Name: temp_sensor_poller

Overview:
Multi-channel, parametrised temperature poller for TMP102-class sensors sharing one I2C bus. Periodically reads a 16-bit temperature from each of NUM_SENSORS slave addresses, in round-robin order, through the existing i2c_master transaction interface. Retries reads that get a NACK and keeps error status per channel. Emits one tagged sample per channel on a valid/ready stream to the sensor aggregation fabric.

Parameters:
NUM_SENSORS, 4, number of polled sensors (1..8)
SENSOR_ADDRS, {7'h4B,7'h4A,7'h49,7'h48}, packed 7*NUM_SENSORS bits; channel k uses bits [7k+6:7k]
POLL_PERIOD, 50000, clk cycles from the end of one sweep to the start of the next (>=2)
MAX_RETRIES, 2, extra attempts per channel after a NACK (0..7)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  polling enable; low aborts synchronously
i2c_start  out  1  one-cycle transaction request to i2c_master
i2c_addr  out  7  slave address for the current channel
i2c_rw_n  out  1  constant 1 (read)
i2c_rdata  in  8  read byte, valid on i2c_done
i2c_done  in  1  transaction complete pulse
i2c_ack_error  in  1  NACK pulse
sample_data  out  16  {MSB byte, LSB byte}
sample_ch  out  CH_W=max(1,$clog2(NUM_SENSORS))  channel index of sample_data
sample_valid  out  1  sample available
sample_ready  in  1  consumer accept
sensor_error  out  NUM_SENSORS  sticky-until-success NACK flag per channel
alarm_hi  in  16  high threshold (feature only; otherwise ignored)
alarm  out  NUM_SENSORS  per-channel over-threshold flag (feature only; otherwise tied 0)

Behaviour:
- Reset values: i2c_start=0, i2c_addr=SENSOR_ADDRS[6:0], sample_data=0, sample_ch=0, sample_valid=0, sensor_error=0, alarm=0, channel=0, retry=0, period counter=POLL_PERIOD-1, state IDLE.
- States: IDLE, REQ_MSB, WAIT_MSB, REQ_LSB, WAIT_LSB, EMIT, NEXT.
- IDLE: the counter decrements each cycle while enable=1. At 0, go to REQ_MSB with channel 0.
- REQ_MSB / REQ_LSB: drive i2c_start=1 for exactly one cycle, then go to the matching WAIT state. i2c_addr stays stable for the whole channel.
- WAIT_x with i2c_done=1: capture i2c_rdata into the MSB or LSB register. WAIT_MSB moves to REQ_LSB; WAIT_LSB moves to EMIT.
- WAIT_x with i2c_ack_error=1 (takes priority over a simultaneous i2c_done):
  - If retry<MAX_RETRIES: retry++, go to REQ_MSB. A failed LSB restarts the whole pair.
  - Otherwise: set sensor_error[ch]=1, go to NEXT, no sample emitted.
- EMIT:
  - Load sample_data and sample_ch, assert sample_valid, clear sensor_error[ch].
  - Hold all three stable until sample_valid&&sample_ready, then deassert next cycle and go to NEXT.
  - sample_ready in the same cycle valid rises is accepted that cycle.
  - Minimum latency from i2c_done of the LSB to sample_valid: 1 cycle.
- NEXT: retry=0.
  - If ch==NUM_SENSORS-1: ch=0, counter=POLL_PERIOD-1, go to IDLE.
  - Else: ch++, go to REQ_MSB immediately. No inter-channel gap beyond one cycle.
- enable low in any state: next cycle go to IDLE, with i2c_start=0, sample_valid=0, ch=0, retry=0, counter=POLL_PERIOD-1. sensor_error and alarm are retained. An in-flight i2c_done or i2c_ack_error arriving later is ignored.
- Stray i2c_done or i2c_ack_error outside the WAIT states: ignored.

Optional Feature:
Macro TEMP_POLLER_ALARM_EN.
- Defined: on each EMIT load, alarm[ch] <= ($signed({MSB,LSB}) > $signed(alarm_hi)). The comparison is signed 16-bit. Channels exhausted by errors keep their previous alarm value.
- Undefined: alarm tied to 0, alarm_hi unused, no comparator logic.

Decomposition:
- iot_sensor_pkg gets typedef enum logic [2:0] poller_state_e (the seven states) and localparam I2C_READ=1'b1.
- Sub-module poller_period_timer: a loadable down-counter with reload, tc (terminal count) and clear-on-disable. It is the natural split.
- All else is inline.

Test Plan:
Setup for all cases: NUM_SENSORS=2, addresses 0x48/0x49, POLL_PERIOD=8, MAX_RETRIES=2, behavioural I2C responder.
1. Clean sweep: responder returns 0x19,0x00 then 0x1A,0x80. Expect samples (ch0, 0x1900) then (ch1, 0x1A80), sensor_error=00, first i2c_start 8 cycles after reset release.
2. Backpressure: hold sample_ready=0 for 20 cycles. Expect sample_valid high and data/ch stable throughout, no new i2c_start, and exactly one sample per channel after release.
3. Retry then success: NACK on the 0x48 LSB once. Expect 3 i2c_start for ch0 before success, sample 0x1900, sensor_error[0]=0.
4. Retry exhaustion: 0x49 always NACKs. Expect 3 attempts, sensor_error=10, no ch1 sample, next sweep starts 8 cycles later. Making 0x49 respond later clears bit 1.
5. enable dropped in WAIT_LSB: expect i2c_start=0, sample_valid=0, later i2c_done ignored. Re-enabling restarts at ch0 after 8 cycles.
6. With TEMP_POLLER_ALARM_EN and alarm_hi=0x1A00: expect alarm=10 after sweep 1. A 0xE700 reading on ch1 clears alarm[1] (signed compare).

Source files
------------

// File: rtl/iot_sensor_pkg.sv
// Shared types for the sensor polling slice.
// Holds the poller FSM state encoding and I2C direction constant.
package iot_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_MSB,
    WAIT_MSB,
    REQ_LSB,
    WAIT_LSB,
    EMIT,
    NEXT
  } poller_state_e;

  localparam logic I2C_READ = 1'b1;

endpackage

// File: rtl/poller_period_timer.sv
// Loadable down-counter that spaces poll sweeps.
// Ports: clk, rst_n, clr/load (reload PERIOD-1), dec (count down), tc (at zero).
module poller_period_timer #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic tc
);

  localparam int W = $clog2(PERIOD);
  localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (clr || load) begin
      cnt_q <= RELOAD;
    end else if (dec && !tc) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/temp_sensor_poller.sv
// Round-robin TMP102-class poller over a shared i2c_master, valid/ready sample out.
// Ports: clk, rst_n, enable, i2c_* request/response, sample_* stream, sensor_error,
// alarm_hi/alarm (compare only when TEMP_POLLER_ALARM_EN is defined, else alarm=0).
module temp_sensor_poller
  import iot_sensor_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter logic [7*NUM_SENSORS-1:0] SENSOR_ADDRS = {7'h4B, 7'h4A, 7'h49, 7'h48},
  parameter int POLL_PERIOD = 50000,
  parameter int MAX_RETRIES = 2,
  localparam int CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   i2c_start,
  output logic [6:0]             i2c_addr,
  output logic                   i2c_rw_n,
  input  logic [7:0]             i2c_rdata,
  input  logic                   i2c_done,
  input  logic                   i2c_ack_error,
  output logic [15:0]            sample_data,
  output logic [CH_W-1:0]        sample_ch,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [NUM_SENSORS-1:0] sensor_error,
  input  logic [15:0]            alarm_hi,
  output logic [NUM_SENSORS-1:0] alarm
);

  poller_state_e state_q, state_d;

  logic [CH_W-1:0] ch_q;
  logic [2:0]      retry_q;
  logic [7:0]      msb_q;

  logic tmr_tc, tmr_dec, tmr_load;
  logic cap_msb, do_emit, do_fail, do_retry, do_accept, do_next;
  logic can_retry, last_ch;

  assign can_retry = (retry_q < 3'(MAX_RETRIES));
  assign last_ch   = (ch_q == CH_W'(NUM_SENSORS - 1));
  assign i2c_start = (state_q == REQ_MSB) || (state_q == REQ_LSB);
  assign i2c_rw_n  = I2C_READ;

  always_comb begin
    i2c_addr = SENSOR_ADDRS[6:0];
    for (int k = 0; k < NUM_SENSORS; k++) begin
      if (ch_q == CH_W'(k)) i2c_addr = SENSOR_ADDRS[7*k +: 7];
    end
  end

  poller_period_timer #(
    .PERIOD (POLL_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!enable),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NACK wins over a same-cycle done; a failed LSB restarts the pair.
  always_comb begin
    state_d   = state_q;
    tmr_dec   = 1'b0;
    tmr_load  = 1'b0;
    cap_msb   = 1'b0;
    do_emit   = 1'b0;
    do_fail   = 1'b0;
    do_retry  = 1'b0;
    do_accept = 1'b0;
    do_next   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          tmr_dec = 1'b1;
          if (tmr_tc) state_d = REQ_MSB;
        end
        REQ_MSB: state_d = WAIT_MSB;
        REQ_LSB: state_d = WAIT_LSB;
        WAIT_MSB, WAIT_LSB: begin
          if (i2c_ack_error) begin
            if (can_retry) begin
              do_retry = 1'b1;
              state_d  = REQ_MSB;
            end else begin
              do_fail = 1'b1;
              state_d = NEXT;
            end
          end else if (i2c_done) begin
            if (state_q == WAIT_MSB) begin
              cap_msb = 1'b1;
              state_d = REQ_LSB;
            end else begin
              do_emit = 1'b1;
              state_d = EMIT;
            end
          end
        end
        EMIT: begin
          if (sample_ready) begin
            do_accept = 1'b1;
            state_d   = NEXT;
          end
        end
        NEXT: begin
          do_next = 1'b1;
          if (last_ch) begin
            tmr_load = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = REQ_MSB;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q         <= '0;
      retry_q      <= '0;
      msb_q        <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      sensor_error <= '0;
    end else if (!enable) begin
      ch_q         <= '0;
      retry_q      <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (cap_msb)  msb_q <= i2c_rdata;
      if (do_retry) retry_q <= retry_q + 1'b1;
      if (do_fail)  sensor_error[ch_q] <= 1'b1;
      if (do_emit) begin
        sample_data        <= {msb_q, i2c_rdata};
        sample_ch          <= ch_q;
        sample_valid       <= 1'b1;
        sensor_error[ch_q] <= 1'b0;
      end
      if (do_accept) sample_valid <= 1'b0;
      if (do_next) begin
        retry_q <= '0;
        ch_q    <= last_ch ? '0 : ch_q + 1'b1;
      end
    end
  end

`ifdef TEMP_POLLER_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= '0;
    end else if (do_emit) begin
      alarm[ch_q] <= $signed({msb_q, i2c_rdata}) > $signed(alarm_hi);
    end
  end
`else
  logic unused_alarm_hi;
  assign unused_alarm_hi = ^alarm_hi;
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_temp_sensor_poller.sv
// Directed bench for temp_sensor_poller: 2 sensors, period 8, 2 retries.
// Behavioural I2C slave answers 3 clocks after each start.
module tb_temp_sensor_poller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        i2c_start;
  logic [6:0]  i2c_addr;
  logic        i2c_rw_n;
  logic [7:0]  i2c_rdata = 8'h00;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_error = 1'b0;
  logic [15:0] sample_data;
  logic [0:0]  sample_ch;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic [1:0]  sensor_error;
  logic [15:0] alarm_hi = 16'h1A00;
  logic [1:0]  alarm;

  always #5 clk = ~clk;

  temp_sensor_poller #(
    .NUM_SENSORS  (2),
    .SENSOR_ADDRS ({7'h49, 7'h48}),
    .POLL_PERIOD  (8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .i2c_start     (i2c_start),
    .i2c_addr      (i2c_addr),
    .i2c_rw_n      (i2c_rw_n),
    .i2c_rdata     (i2c_rdata),
    .i2c_done      (i2c_done),
    .i2c_ack_error (i2c_ack_error),
    .sample_data   (sample_data),
    .sample_ch     (sample_ch),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sensor_error  (sensor_error),
    .alarm_hi      (alarm_hi),
    .alarm         (alarm)
  );

`ifdef TEMP_POLLER_ALARM_EN
  localparam logic [1:0] ALARM_SWEEP1 = 2'b10;
`else
  localparam logic [1:0] ALARM_SWEEP1 = 2'b00;
`endif

  logic [7:0] m48 = 8'h19, l48 = 8'h00;
  logic [7:0] m49 = 8'h1A, l49 = 8'h80;
  logic       nack49 = 1'b0;
  int         nack48_lsb = 0;
  logic       phase = 1'b0;
  logic       busy = 1'b0;
  int         dly = 0;
  logic [6:0] r_addr;
  logic       r_phase;

  always @(negedge clk) begin
    i2c_done      = 1'b0;
    i2c_ack_error = 1'b0;
    if (busy) begin
      dly = dly - 1;
      if (dly == 0) begin
        busy = 1'b0;
        if ((r_addr == 7'h49 && nack49) ||
            (r_addr == 7'h48 && r_phase && nack48_lsb > 0)) begin
          if (r_addr == 7'h48) nack48_lsb = nack48_lsb - 1;
          i2c_ack_error = 1'b1;
          phase = 1'b0;
        end else begin
          if (r_addr == 7'h48) i2c_rdata = r_phase ? l48 : m48;
          else                 i2c_rdata = r_phase ? l49 : m49;
          i2c_done = 1'b1;
          phase = ~r_phase;
        end
      end
    end else if (rst_n && i2c_start) begin
      busy    = 1'b1;
      dly     = 2;
      r_addr  = i2c_addr;
      r_phase = phase;
    end
  end

  int          st48 = 0, st49 = 0;
  logic [15:0] q_data[$];
  logic [0:0]  q_ch[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (i2c_start && i2c_addr == 7'h48) st48 = st48 + 1;
      if (i2c_start && i2c_addr == 7'h49) st49 = st49 + 1;
      if (sample_valid && sample_ready) begin
        q_data.push_back(sample_data);
        q_ch.push_back(sample_ch);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag, input int exp_n);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (i2c_start) break;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic wait_samples(input string tag, input int k);
    int n;
    n = 0;
    while (q_data.size() < k && n < 300) begin
      tick();
      n++;
    end
    chk(tag, q_data.size(), k);
  endtask

  task automatic restart();
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (12) @(posedge clk);
    q_data.delete();
    q_ch.delete();
    st48  = 0;
    st49  = 0;
    phase = 1'b0;
    #1 enable = 1'b1;
    wait_start("restart_gap", 8);
    chk("restart_addr", i2c_addr, 7'h48);
  endtask

  initial begin
    int          n, bad, s0;
    logic [15:0] d0;
    logic [0:0]  c0;

    // reset values
    repeat (3) tick();
    chk("rst_start", i2c_start, 1'b0);
    chk("rst_addr", i2c_addr, 7'h48);
    chk("rst_rw_n", i2c_rw_n, 1'b1);
    chk("rst_data", sample_data, 16'h0000);
    chk("rst_ch", sample_ch, 1'b0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_err", sensor_error, 2'b00);
    chk("rst_alarm", alarm, 2'b00);

    // 1: clean sweep
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_start("t1_first_start", 8);
    wait_samples("t1_samples", 2);
    chk("t1_ch0", q_ch[0], 1'b0);
    chk("t1_d0", q_data[0], 16'h1900);
    chk("t1_ch1", q_ch[1], 1'b1);
    chk("t1_d1", q_data[1], 16'h1A80);
    chk("t1_st48", st48, 2);
    chk("t1_st49", st49, 2);
    chk("t1_err", sensor_error, 2'b00);
    tick();
    chk("t1_alarm", alarm, ALARM_SWEEP1);

    // 2: backpressure
    sample_ready = 1'b0;
    restart();
    n = 0;
    while (!sample_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t2_valid_seen", sample_valid, 1'b1);
    d0  = sample_data;
    c0  = sample_ch;
    s0  = st48 + st49;
    bad = 0;
    repeat (20) begin
      tick();
      if (!sample_valid || sample_data !== d0 || sample_ch !== c0 ||
          (st48 + st49) != s0) bad++;
    end
    chk("t2_stable", bad, 0);
    chk("t2_held_data", d0, 16'h1900);
    chk("t2_held_ch", c0, 1'b0);
    chk("t2_none_taken", q_data.size(), 0);
    @(posedge clk);
    #1 sample_ready = 1'b1;
    wait_samples("t2_samples", 2);
    chk("t2_d0", q_data[0], 16'h1900);
    chk("t2_d1", q_data[1], 16'h1A80);
    repeat (3) tick();
    chk("t2_one_per_ch", q_data.size(), 2);

    // 3: one NACK on 0x48 LSB, then success
    nack48_lsb = 1;
    restart();
    wait_samples("t3_samples", 1);
    chk("t3_st48", st48, 4);
    chk("t3_ch0", q_ch[0], 1'b0);
    chk("t3_d0", q_data[0], 16'h1900);
    chk("t3_err0", sensor_error[0], 1'b0);
    wait_samples("t3_samples2", 2);
    chk("t3_err", sensor_error, 2'b00);

    // 4: 0x49 always NACKs, then recovers
    nack49 = 1'b1;
    restart();
    wait_samples("t4_ch0_sample", 1);
    n = 0;
    while (st49 < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_attempts_seen", st49, 3);
    n = 0;
    while (!i2c_ack_error && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_final_nack", i2c_ack_error, 1'b1);
    wait_start("t4_next_sweep", 10);
    chk("t4_next_addr", i2c_addr, 7'h48);
    chk("t4_err", sensor_error, 2'b10);
    chk("t4_attempts", st49, 3);
    chk("t4_no_ch1", q_data.size(), 1);
    nack49 = 1'b0;
    wait_samples("t4_recover", 3);
    chk("t4_rec_ch", q_ch[2], 1'b1);
    chk("t4_rec_data", q_data[2], 16'h1A80);
    chk("t4_err_clear", sensor_error, 2'b00);

    // 5: enable dropped in WAIT_LSB
    restart();
    n = 0;
    while (st48 < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_lsb_req", st48, 2);
    @(posedge clk);
    #1 enable = 1'b0;
    tick();
    chk("t5_start_off", i2c_start, 1'b0);
    chk("t5_valid_off", sample_valid, 1'b0);
    chk("t5_addr_ch0", i2c_addr, 7'h48);
    repeat (6) tick();
    chk("t5_no_sample", q_data.size(), 0);
    chk("t5_no_start", st48 + st49, 2);
    restart();
    wait_samples("t5_resume", 2);
    chk("t5_d0", q_data[0], 16'h1900);
    chk("t5_ch0", q_ch[0], 1'b0);

`ifdef TEMP_POLLER_ALARM_EN
    // 6: signed alarm compare
    m49 = 8'hE7;
    l49 = 8'h00;
    restart();
    wait_samples("t6_samples", 2);
    chk("t6_d1", q_data[1], 16'hE700);
    tick();
    chk("t6_alarm", alarm, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
